// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the multiplier arbiter slice.
package fpu_pkg;
  localparam int FP_W     = 32;
  localparam int MAX_ID_W = 3;

  typedef logic [FP_W-1:0] fp32_t;

  localparam fp32_t FP_ONE  = 32'h3F800000;
  localparam fp32_t FP_QNAN = 32'h7FC00000;

  // One slot of the tagged result pipeline.
  typedef struct packed {
    logic                v;
    logic [MAX_ID_W-1:0] id;
    fp32_t               data;
  } mul_stage_t;
endpackage

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible index at or after rr_ptr.
module fpu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);
  logic [ID_W-1:0] rr_ptr;
  logic            found;
  int              idx;

  // Search upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

  // Advance the pointer past the winner only when the grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/multi.sv
// Combinational single-precision multiplier: round-to-nearest-even,
// denormal inputs and underflowing results flush to signed zero.
module multi (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] op
);
  logic              sign;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]       prod;
  logic signed [9:0] exp_s;
  logic [22:0]       frac;
  logic              round_bit;
  logic              sticky;
  logic              rnd;
  logic [23:0]       mant_r;

  // Classify operands, multiply mantissas, normalise, round and pack.
  always_comb begin
    sign   = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      frac      = prod[46:24];
      round_bit = prod[23];
      sticky    = |prod[22:0];
      exp_s     = exp_s + 10'sd1;
    end else begin
      frac      = prod[45:23];
      round_bit = prod[22];
      sticky    = |prod[21:0];
    end
    rnd    = round_bit & (sticky | frac[0]);
    mant_r = {1'b0, frac} + {23'd0, rnd};
    // A carry out of the fraction means 1.111.. rounded up to 10.000..
    if (mant_r[23]) begin
      exp_s = exp_s + 10'sd1;
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      op = 32'h7FC00000;
    end else if (a_inf || b_inf) begin
      op = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      op = {sign, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      op = {sign, 8'hFF, 23'd0};
    end else if (exp_s <= 10'sd0) begin
      op = {sign, 31'd0};
    end else begin
      op = {sign, exp_s[7:0], mant_r[22:0]};
    end
  end
endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one combinational fp32 multiplier among NUM_REQ requesters with a
// fixed-latency, id-tagged result pipeline.
module fpu_mul_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      cfg_mask,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [FP_W-1:0]         resp_data,
  output logic                    idle,
  output logic [15:0]             op_count
);
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                accept;
  fp32_t               sel_a;
  fp32_t               sel_b;
  logic                issue_v;
  logic [MAX_ID_W-1:0] issue_id;
  fp32_t               issue_a;
  fp32_t               issue_b;
  fp32_t               mul_op;
  mul_stage_t          stage [LATENCY-1];
  logic                any_v;
  logic                unused_id;

  assign eligible  = req_valid & cfg_mask;
  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign sel_a     = req_a[int'(grant_idx)*FP_W +: FP_W];
  assign sel_b     = req_b[int'(grant_idx)*FP_W +: FP_W];

  fpu_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .accept   (accept),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Issue stage: capture the winner's tag and operands at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_v  <= 1'b0;
      issue_id <= '0;
      issue_a  <= '0;
      issue_b  <= '0;
    end else begin
      issue_v <= accept;
      if (accept) begin
        issue_id <= MAX_ID_W'(grant_idx);
        issue_a  <= sel_a;
        issue_b  <= sel_b;
      end
    end
  end

  multi u_multi (
    .a (issue_a),
    .b (issue_b),
    .op(mul_op)
  );

  // Result pipeline: v always advances, id/data load only with a valid
  // entry so the output holds its last product between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY - 1; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].v <= issue_v;
      if (issue_v) begin
        stage[0].id   <= issue_id;
        stage[0].data <= mul_op;
      end
      for (int i = 1; i < LATENCY - 1; i++) begin
        stage[i].v <= stage[i-1].v;
        if (stage[i-1].v) begin
          stage[i].id   <= stage[i-1].id;
          stage[i].data <= stage[i-1].data;
        end
      end
    end
  end

  // Pipeline occupancy for the idle indication.
  always_comb begin
    any_v = issue_v;
    for (int i = 0; i < LATENCY - 1; i++) begin
      any_v = any_v | stage[i].v;
    end
  end

  assign resp_valid = stage[LATENCY-2].v;
  assign resp_id    = stage[LATENCY-2].id[ID_W-1:0];
  assign resp_data  = stage[LATENCY-2].data;
  assign idle       = ~(|eligible) & ~any_v;
  assign unused_id  = ^stage[LATENCY-2].id;

  // Completed-operation counter, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= 16'd0;
    end else if (resp_valid) begin
      op_count <= op_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed self-checking bench for fpu_mul_arbiter (NUM_REQ=4, LATENCY=2).
module tb_fpu_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LATENCY = 2;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   cfg_mask;
  logic                 resp_valid;
  logic [ID_W-1:0]      resp_id;
  logic [31:0]          resp_data;
  logic                 idle;
  logic [15:0]          op_count;

  int   errors = 0;
  int   checks = 0;
  logic verbose = 1'b1;
  logic [3:0] exp_g;

  fpu_mul_arbiter #(
    .NUM_REQ(NUM_REQ),
    .LATENCY(LATENCY),
    .ID_W   (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .cfg_mask  (cfg_mask),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .idle      (idle),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // One line per response transaction during directed sections.
  always @(negedge clk) begin
    if (verbose && resp_valid === 1'b1)
      $display("resp id=%0d data=%h op_count=%0d", resp_id, resp_data, op_count);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    cfg_mask  = 4'hF;
    req_a     = '0;
    req_b     = '0;
    step();

    // Reset state
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_op_count", op_count, 0);
    check("rst_idle", idle, 1);
    check("rst_ready_none", req_ready, 0);
    req_valid = 4'b0001;
    #1;
    check("ready_during_reset", req_ready, 4'b0001);
    req_valid = '0;
    step();
    rst_n = 1'b1;

    // Single op: 3.0 * 2.0 from requester 0
    req_a[31:0] = 32'h40400000;
    req_b[31:0] = 32'h40000000;
    req_valid   = 4'b0001;
    #1;
    check("t1_ready", req_ready, 4'b0001);
    check("t1_idle_busy", idle, 0);
    step();
    req_valid = '0;
    check("t1_no_early_resp", resp_valid, 0);
    step();
    check("t1_resp_valid", resp_valid, 1);
    check("t1_resp_id", resp_id, 0);
    check("t1_resp_data", resp_data, 32'h40C00000);
    check("t1_count_before", op_count, 0);
    step();
    check("t1_resp_done", resp_valid, 0);
    check("t1_op_count", op_count, 1);
    check("t1_data_hold", resp_data, 32'h40C00000);
    check("t1_idle", idle, 1);

    // Fairness: all four valid, 1.5 * -4.0
    do_reset();
    req_a     = {4{32'h3FC00000}};
    req_b     = {4{32'hC0800000}};
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_g = 4'(1 << (k % 4));
      check("t2_grant", req_ready, exp_g);
      step();
      if (k >= 1) begin
        check("t2_resp_valid", resp_valid, 1);
        check("t2_resp_id", resp_id, 32'((k - 1) % 4));
        check("t2_resp_data", resp_data, 32'hC0C00000);
      end
    end
    req_valid = '0;
    step();
    check("t2_last_valid", resp_valid, 1);
    check("t2_last_id", resp_id, 3);
    step();
    check("t2_drained", resp_valid, 0);
    check("t2_op_count", op_count, 8);

    // Masked requester 3, requester 1 granted every cycle
    cfg_mask  = 4'b0111;
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_ready", req_ready, 4'b0010);
      check("t3_idle", idle, 0);
      step();
    end
    req_valid = 4'b0010;
    cfg_mask  = 4'b0101;
    #1;
    check("t3_mask_clear", req_ready, 4'b0000);
    req_valid = '0;
    cfg_mask  = 4'hF;
    step();
    step();
    step();

    // Reset mid-stream: one op issued, another being presented
    req_valid = 4'b0001;
    step();
    rst_n = 1'b0;
    #1;
    check("t4_resp_cleared", resp_valid, 0);
    check("t4_count_cleared", op_count, 0);
    req_valid = 4'hF;
    #1;
    check("t4_ptr_reset", req_ready, 4'b0001);
    step();
    step();
    check("t4_no_resp_in_reset", resp_valid, 0);
    rst_n = 1'b1;
    #1;
    check("t4_first_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    check("t4_no_stale_resp", resp_valid, 0);
    step();
    check("t4_new_resp", resp_valid, 1);
    check("t4_new_id", resp_id, 0);
    step();
    check("t4_count", op_count, 1);

    // Inf * 0 from requester 2
    do_reset();
    req_a[95:64] = 32'h7F800000;
    req_b[95:64] = 32'h00000000;
    req_valid    = 4'b0100;
    #1;
    check("t5_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    check("t5_resp_valid", resp_valid, 1);
    check("t5_resp_id", resp_id, 2);
    check("t5_resp_data", resp_data, 32'h7FC00000);

    // op_count wrap after 65536 operations
    verbose = 1'b0;
    do_reset();
    req_valid = 4'b0001;
    repeat (65535) step();
    req_valid = '0;
    repeat (4) step();
    check("t6_count_max", op_count, 16'hFFFF);
    check("t6_idle", idle, 1);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    check("t6_resp_valid", resp_valid, 1);
    step();
    check("t6_count_wrap", op_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
